// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one buart transmitter among NUM_REQ byte-stream
// requesters. A grant is held for a whole message, until the owner's last byte
// has left the transmitter. Requesters must hold valid/data/last stable until acked.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned GUARD       = 2,
   parameter int unsigned MSG_TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   resetq,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   uart_wr,
   output logic [7:0]             uart_tx_data,
   input  logic                   uart_busy,
   output logic                   timeout_evt
);

   localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W  = (MSG_TIMEOUT > 1) ? $clog2(MSG_TIMEOUT + 1) : 1;
   localparam int unsigned GCNT_W = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_GUARD   = 2'd2,
      ST_WAIT_TX = 2'd3
   } state_t;

   state_t              state;
   logic [PTR_W-1:0]    owner;
   logic [PTR_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]    idle_cnt;
   logic [GCNT_W-1:0]   guard_cnt;
   logic                last_r;

   logic                pick_found;
   logic [PTR_W-1:0]    pick_idx;
   logic                owner_valid;
   logic                owner_last;
   logic [7:0]          owner_data;
   logic [PTR_W-1:0]    next_ptr;
   logic                timeout_hit;

   // Index base+k wrapped into 0..NUM_REQ-1 (NUM_REQ need not be a power of two)
   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                 input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   // First valid requester at or after rr_ptr, wrapping
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[rr_index(rr_ptr, k)]) begin
            pick_found = 1'b1;
            pick_idx   = rr_index(rr_ptr, k);
         end
      end
   end

   // Owner's request lines, release pointer and timeout condition
   always_comb begin
      owner_valid = req_valid[owner];
      owner_last  = req_last[owner];
      owner_data  = req_data[{owner, 3'b000} +: 8];
      next_ptr    = (32'(owner) == NUM_REQ - 1) ? '0 : owner + PTR_W'(1);
      timeout_hit = (MSG_TIMEOUT != 0) && ((32'(idle_cnt) + 32'd1) >= MSG_TIMEOUT);
   end

   // Message-level arbitration FSM with registered strobes
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state        <= ST_IDLE;
         owner        <= '0;
         rr_ptr       <= '0;
         idle_cnt     <= '0;
         guard_cnt    <= '0;
         last_r       <= 1'b0;
         grant        <= '0;
         req_ack      <= '0;
         uart_wr      <= 1'b0;
         uart_tx_data <= 8'h00;
         timeout_evt  <= 1'b0;
      end else begin
         uart_wr     <= 1'b0;
         req_ack     <= '0;
         timeout_evt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  owner    <= pick_idx;
                  grant    <= NUM_REQ'(1) << pick_idx;
                  idle_cnt <= '0;
                  state    <= ST_SEND;
               end else begin
                  grant <= '0;
               end
            end
            ST_SEND: begin
               if (owner_valid && !uart_busy) begin
                  uart_tx_data <= owner_data;
                  uart_wr      <= 1'b1;
                  req_ack      <= NUM_REQ'(1) << owner;
                  last_r       <= owner_last;
                  guard_cnt    <= '0;
                  idle_cnt     <= '0;
                  state        <= ST_GUARD;
               end else if (owner_valid) begin
                  // stalled on busy only: not an idle owner
                  idle_cnt <= '0;
               end else if (timeout_hit) begin
                  grant       <= '0;
                  timeout_evt <= 1'b1;
                  rr_ptr      <= next_ptr;
                  idle_cnt    <= '0;
                  state       <= ST_IDLE;
               end else if (idle_cnt != '1) begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end
            ST_GUARD: begin
               // spans the ack cycle and buart busy rise latency
               if (32'(guard_cnt) >= GUARD - 1) begin
                  state <= ST_WAIT_TX;
               end else begin
                  guard_cnt <= guard_cnt + GCNT_W'(1);
               end
            end
            ST_WAIT_TX: begin
               if (!uart_busy) begin
                  if (last_r) begin
                     grant  <= '0;
                     rr_ptr <= next_ptr;
                     state  <= ST_IDLE;
                  end else begin
                     idle_cnt <= '0;
                     state    <= ST_SEND;
                  end
               end
            end
            default: begin
               grant <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues, a buart busy
// model, and a scoreboard of expected (requester, byte) pairs checked on each uart_wr.
module tb_uart_tx_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned GD = 2;
   localparam int unsigned TO = 16;

   logic              clk = 1'b0;
   logic              resetq = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [8*NR-1:0]   req_data = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR-1:0]     req_ack;
   logic [NR-1:0]     grant;
   logic              uart_wr;
   logic [7:0]        uart_tx_data;
   logic              uart_busy;
   logic              timeout_evt;

   logic [8:0]        rq [NR][$];
   logic [9:0]        exp_q [$];
   int                checks = 0;
   int                errors = 0;
   int                wr_count = 0;
   int                ack_count = 0;
   int                to_count = 0;
   int                frame = 20;
   int                busy_cnt = 0;
   logic              force_busy = 1'b0;
   logic              prev_wr = 1'b0;

   uart_tx_arbiter #(.NUM_REQ(NR), .GUARD(GD), .MSG_TIMEOUT(TO)) dut (
      .clk(clk), .resetq(resetq), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ack(req_ack), .grant(grant), .uart_wr(uart_wr),
      .uart_tx_data(uart_tx_data), .uart_busy(uart_busy), .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   // buart model: busy rises one edge after wr and lasts frame cycles
   always @(posedge clk) begin
      if (uart_wr) busy_cnt <= frame;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign uart_busy = force_busy || (busy_cnt != 0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic enq(input int idx, input logic [7:0] d, input logic l);
      rq[idx].push_back({l, d});
   endtask

   task automatic expect_byte(input int idx, input logic [7:0] d);
      exp_q.push_back({2'(idx), d});
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
      return exp_q.size() == 0;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while ((!all_empty() || grant != '0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(n < 3000), 32'd1);
   endtask

   // Requester models: pop on ack, present queue head
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (req_ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            if (rq[i].size() != 0) begin
               req_valid[i]         = 1'b1;
               req_data[8*i +: 8]   = rq[i][0][7:0];
               req_last[i]          = rq[i][0][8];
            end else begin
               req_valid[i]         = 1'b0;
               req_data[8*i +: 8]   = 8'h00;
               req_last[i]          = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor on uart_wr
   always @(negedge clk) begin
      logic [9:0]    e;
      logic [NR-1:0] oh;
      if (!resetq) begin
         prev_wr = 1'b0;
      end else begin
         if (uart_wr) begin
            wr_count++;
            check("wr_single_cycle", 32'(prev_wr), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_wr", 32'd1, 32'd0);
            end else begin
               e  = exp_q.pop_front();
               oh = NR'(1) << e[9:8];
               check("tx_data", 32'(uart_tx_data), 32'(e[7:0]));
               check("ack_idx", 32'(req_ack), 32'(oh));
               check("grant_idx", 32'(grant), 32'(oh));
            end
         end
         if (req_ack != '0) ack_count++;
         if (timeout_evt) to_count++;
         prev_wr = uart_wr;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      resetq = 1'b0;
      repeat (2) @(negedge clk);
      resetq = 1'b1;
   endtask

   initial begin
      int w0, a0, t0, n;
      bit seen;

      // reset values
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_wr", 32'(uart_wr), 32'd0);
      check("rst_data", 32'(uart_tx_data), 32'd0);
      check("rst_ack", 32'(req_ack), 32'd0);
      check("rst_timeout", 32'(timeout_evt), 32'd0);
      @(negedge clk);
      resetq = 1'b1;

      // A: three-byte message from req0
      w0 = wr_count; a0 = ack_count;
      enq(0, 8'h41, 1'b0); enq(0, 8'h42, 1'b0); enq(0, 8'h43, 1'b1);
      expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
      wait_idle();
      check("A_wr_count", 32'(wr_count - w0), 32'd3);
      check("A_ack_count", 32'(ack_count - a0), 32'd3);
      check("A_grant_end", 32'(grant), 32'd0);

      // B: simultaneous req1/req3 from rr_ptr=0, then req0/req2 shows pointer wrapped to 0
      do_reset();
      enq(1, 8'h11, 1'b1); enq(3, 8'h33, 1'b1);
      expect_byte(1, 8'h11); expect_byte(3, 8'h33);
      wait_idle();
      enq(2, 8'h22, 1'b1); enq(0, 8'h00, 1'b1);
      expect_byte(0, 8'h00); expect_byte(2, 8'h22);
      wait_idle();

      // C: req0 locked out during req2's 4-byte message
      frame = 6;
      enq(2, 8'hC0, 1'b0); enq(2, 8'hC1, 1'b0); enq(2, 8'hC2, 1'b0); enq(2, 8'hC3, 1'b1);
      expect_byte(2, 8'hC0); expect_byte(2, 8'hC1); expect_byte(2, 8'hC2);
      expect_byte(2, 8'hC3); expect_byte(0, 8'hA0);
      n = 0;
      while (!uart_wr && n < 200) begin @(negedge clk); n++; end
      enq(0, 8'hA0, 1'b1);
      wait_idle();

      // D: req1 abandons its message, forced release
      frame = 20;
      t0 = to_count;
      enq(1, 8'h55, 1'b0);
      expect_byte(1, 8'h55);
      n = 0;
      while (!uart_wr && n < 200) begin @(negedge clk); n++; end
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk); n++;
         if (timeout_evt) seen = 1'b1;
      end
      check("D_timeout_seen", 32'(seen), 32'd1);
      check("D_timeout_window", 32'(n >= 16 && n <= 16 + 20 + GD + 4), 32'd1);
      check("D_grant_released", 32'(grant), 32'd0);
      repeat (3) @(negedge clk);
      check("D_timeout_pulses", 32'(to_count - t0), 32'd1);
      wait_idle();

      // E: async reset while req2 is in GUARD; rr_ptr returns to 0
      enq(2, 8'h60, 1'b1);
      expect_byte(2, 8'h60);
      n = 0;
      while (!uart_wr && n < 200) begin @(negedge clk); n++; end
      #2 resetq = 1'b0;
      #1;
      check("E_rst_grant", 32'(grant), 32'd0);
      check("E_rst_ack", 32'(req_ack), 32'd0);
      check("E_rst_wr", 32'(uart_wr), 32'd0);
      check("E_rst_data", 32'(uart_tx_data), 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetq = 1'b1;
      enq(2, 8'h77, 1'b1); enq(0, 8'h70, 1'b1);
      expect_byte(0, 8'h70); expect_byte(2, 8'h77);
      wait_idle();

      // F: busy held high with req0 valid
      n = 0;
      while (busy_cnt != 0 && n < 200) begin @(negedge clk); n++; end
      force_busy = 1'b1;
      enq(0, 8'h99, 1'b1);
      expect_byte(0, 8'h99);
      n = 0;
      while (grant != 4'b0001 && n < 20) begin @(negedge clk); n++; end
      w0 = wr_count; a0 = ack_count; t0 = to_count;
      repeat (100) @(negedge clk);
      check("F_no_wr", 32'(wr_count - w0), 32'd0);
      check("F_no_ack", 32'(ack_count - a0), 32'd0);
      check("F_no_timeout", 32'(to_count - t0), 32'd0);
      check("F_grant_held", 32'(grant), 32'd1);
      force_busy = 1'b0;
      @(negedge clk);
      check("F_wr_after_busy", 32'(uart_wr), 32'd1);
      wait_idle();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
